mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared processor constants and MEM-stage FSM encoding
//
// Purpose : data/register widths, default bus timeout and the state
//           encoding used by the memory-access stage.
// Ports   : none (package).
package mem_access_unit_pkg;

  localparam int DATA_W          = 16;
  localparam int REG_W           = 3;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/acknowledge bus
//
// Purpose : groups the data-memory bus signals of the MEM stage.
// Ports   : master (MEM stage) drives mem_req, mem_we, mem_addr, mem_wdata
//           and receives mem_rdata, mem_ack (one-cycle completion pulse);
//           slave (memory) is the mirror image.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage with stalling data-memory access and bus timeout
//
// Purpose : executes loads/stores from the EXE/MEM register over a
//           request/ack bus, stalls the front of the pipeline while an
//           access is outstanding and feeds the MEM/WB register.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           Rd3In..ALUOutIn       - EXE/MEM register fields
//           stall                 - holds IF..EXE/MEM while high (combinational)
//           bus (master)          - data-memory bus
//           Rd3Out, RegWrOut,
//           WBDataOut             - MEM/WB register fields
//           err                   - sticky bus-timeout flag, cleared by reset only
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  Rd3In,
  input  logic              RegWrIn,
  input  logic              MemRIn,
  input  logic              MemWIn,
  input  logic              WBIn,
  input  logic [DATA_W-1:0] DataInIn,
  input  logic [DATA_W-1:0] ALUOutIn,
  output logic              stall,
  mem_access_unit_if.master bus,
  output logic [REG_W-1:0]  Rd3Out,
  output logic              RegWrOut,
  output logic [DATA_W-1:0] WBDataOut,
  output logic              err
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  // Value of the counter on the last WAIT cycle allowed before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              start;
  logic              timeout_hit;

  assign start       = MemRIn | MemWIn;
  // An ack on the expiring cycle wins, so it is excluded here.
  assign timeout_hit = (state == S_WAIT) && !bus.mem_ack && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_WAIT;
      S_WAIT: if (bus.mem_ack || timeout_hit) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE: stall = start;
      S_WAIT: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Bus registers, read-data capture, timeout counter and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rdata_q       <= '0;
      cnt           <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= MemWIn;  // store wins when both are set
            bus.mem_addr  <= ALUOutIn;
            bus.mem_wdata <= DataInIn;
            cnt           <= '0;
          end
        end
        S_WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) rdata_q <= bus.mem_rdata;
          end else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            err         <= 1'b1;
            if (!bus.mem_we) rdata_q <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise pass the instruction on
  always_ff @(posedge clk) begin
    if (reset) begin
      Rd3Out    <= '0;
      RegWrOut  <= 1'b0;
      WBDataOut <= '0;
    end else if (stall) begin
      RegWrOut  <= 1'b0;
    end else begin
      Rd3Out    <= Rd3In;
      RegWrOut  <= RegWrIn;
      WBDataOut <= WBIn ? rdata_q : ALUOutIn;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  Rd3In;
  logic        RegWrIn, MemRIn, MemWIn, WBIn;
  logic [15:0] DataInIn, ALUOutIn;
  logic        stall;
  logic [2:0]  Rd3Out;
  logic        RegWrOut;
  logic [15:0] WBDataOut;
  logic        err;

  int checks = 0;
  int fails  = 0;

  // Reference view of the stage: MEM/WB contents, last load data, sticky error
  logic [2:0]  e_rd3;
  logic        e_regwr;
  logic [15:0] e_wb;
  logic [15:0] e_rdq;
  logic        e_err;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .Rd3In     (Rd3In),
    .RegWrIn   (RegWrIn),
    .MemRIn    (MemRIn),
    .MemWIn    (MemWIn),
    .WBIn      (WBIn),
    .DataInIn  (DataInIn),
    .ALUOutIn  (ALUOutIn),
    .stall     (stall),
    .bus       (bus),
    .Rd3Out    (Rd3Out),
    .RegWrOut  (RegWrOut),
    .WBDataOut (WBDataOut),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_rd3 = '0; e_regwr = 1'b0; e_wb = '0; e_rdq = '0; e_err = 1'b0;
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_rd3"},   16'(Rd3Out),   16'(e_rd3));
    chk({tag, "_regwr"}, 16'(RegWrOut), 16'(e_regwr));
    chk({tag, "_wbdata"}, WBDataOut,    e_wb);
    chk({tag, "_err"},   16'(err),      16'(e_err));
  endtask

  // One instruction from first presentation to its MEM/WB result.
  // d = WAIT cycle (1-based) on which the memory acks; 0 or >TO = never.
  task automatic run_instr(input logic [2:0] rd, input logic rw, input logic mr,
                           input logic mw, input logic wb, input logic [15:0] din,
                           input logic [15:0] alu, input int d, input logic [15:0] rdv);
    int   wlen;
    logic acked;
    logic is_mem;
    Rd3In = rd; RegWrIn = rw; MemRIn = mr; MemWIn = mw; WBIn = wb;
    DataInIn = din; ALUOutIn = alu;
    // Stray ack while IDLE must be ignored
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = 16'($urandom);
    is_mem = mr | mw;
    #1;
    chk("stall_first", 16'(stall), 16'(is_mem));
    if (!is_mem) begin
      tick();
      e_rd3 = rd; e_regwr = rw; e_wb = wb ? e_rdq : alu;
    end else begin
      acked = (d >= 1) && (d <= TO);
      wlen  = acked ? d : TO;
      tick();
      for (int k = 1; k <= wlen; k++) begin
        bus.mem_ack   = (k == d);
        bus.mem_rdata = (k == d) ? rdv : 16'($urandom);
        #1;
        chk("wait_req",   16'(bus.mem_req), 16'd1);
        chk("wait_addr",  bus.mem_addr,     alu);
        chk("wait_we",    16'(bus.mem_we),  16'(mw));
        chk("wait_wdata", bus.mem_wdata,    din);
        chk("wait_stall", 16'(stall),       16'd1);
        chk("wait_regwr", 16'(RegWrOut),    16'd0);
        chk("wait_rd3",   16'(Rd3Out),      16'(e_rd3));
        chk("wait_wb",    WBDataOut,        e_wb);
        chk("wait_err",   16'(err),         16'(e_err));
        tick();
      end
      if (!mw) e_rdq = acked ? rdv : 16'h0000;
      if (!acked) e_err = 1'b1;
      // Stray ack in DONE must be ignored
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'hDEAD;
      #1;
      chk("done_req",   16'(bus.mem_req), 16'd0);
      chk("done_stall", 16'(stall),       16'd0);
      chk("done_regwr", 16'(RegWrOut),    16'd0);
      chk("done_err",   16'(err),         16'(e_err));
      tick();
      e_rd3 = rd; e_regwr = rw; e_wb = wb ? e_rdq : alu;
    end
    bus.mem_ack = 1'b0;
    chk_wb("result");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    Rd3In = '0; RegWrIn = 0; MemRIn = 0; MemWIn = 0; WBIn = 0;
    DataInIn = '0; ALUOutIn = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    model_reset();
    tick();
    tick();
    chk("rst_req",   16'(bus.mem_req), 16'd0);
    chk("rst_we",    16'(bus.mem_we),  16'd0);
    chk("rst_addr",  bus.mem_addr,     16'h0000);
    chk("rst_wdata", bus.mem_wdata,    16'h0000);
    chk("rst_stall", 16'(stall),       16'd0);
    chk_wb("rst");
    reset = 1'b0;

    // Non-memory instruction, one-cycle latency
    run_instr(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 0, 16'h0);
    // Load, ack on first WAIT cycle
    run_instr(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040, 1, 16'hBEEF);
    // Store, ack after 3 WAIT cycles
    run_instr(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5A5, 16'h0010, 3, 16'h0);
    // Both MemR and MemW: treated as a write, load data unchanged
    run_instr(3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'h0020, 2, 16'h1111);
    // Ack exactly on the expiring cycle is a success
    run_instr(3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0030, TO, 16'hC0DE);
    // Two back-to-back loads
    run_instr(3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0100, 1, 16'h1357);
    run_instr(3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0101, 2, 16'h2468);
    // Load timeout: err sets, data forced to zero
    run_instr(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0200, 0, 16'h0);
    // err remains set afterwards
    run_instr(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h4321, 0, 16'h0);

    // Reset in the second WAIT cycle
    Rd3In = 3'd2; RegWrIn = 1; MemRIn = 1; MemWIn = 0; WBIn = 1;
    DataInIn = 16'h0000; ALUOutIn = 16'h0080; bus.mem_ack = 1'b0;
    tick();
    tick();
    chk("mid_req", 16'(bus.mem_req), 16'd1);
    reset = 1'b1;
    Rd3In = '0; RegWrIn = 0; MemRIn = 0; WBIn = 0; ALUOutIn = '0;
    tick();
    model_reset();
    chk("mrst_req",   16'(bus.mem_req), 16'd0);
    chk("mrst_we",    16'(bus.mem_we),  16'd0);
    chk("mrst_addr",  bus.mem_addr,     16'h0000);
    chk("mrst_stall", 16'(stall),       16'd0);
    chk("mrst_state", 16'(dut.state),   16'(S_IDLE));
    chk_wb("mrst");
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_req",   16'(bus.mem_req), 16'd0);
    chk("late_state", 16'(dut.state),   16'(S_IDLE));
    // Late ack must not have loaded read data
    run_instr(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h9999, 0, 16'h0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      logic mr, mw;
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 2) == 0);
      run_instr(3'($urandom), 1'($urandom), mr, mw, 1'($urandom),
                16'($urandom), 16'($urandom), $urandom_range(0, 17), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
